host_cmd_seq: RTL and testbench
===============================

# host_cmd_seq

Host command sequencer for the S1D13700-compatible LCD controller. It sits behind the synchronized 8080-style host bus (cs_x/a0/wr_x/dat) inside monitor_top. It decodes command and parameter bytes, routes parameters to the control register file, tracks the cursor address, and buffers MWRITE display data into a small FIFO that drains to VRAM through a req/ack handshake.

## Interface
- FIFO_DEPTH, 4: MWRITE FIFO entries (power of two, ≥2)
- ADDR_W, 16: VRAM/cursor address width
- clk  in  1  system clock (P_MCLKI domain)
- rst  in  1  synchronous reset, active-high
- cs_x  in  1  chip select, active-low, pre-synchronized
- a0  in  1  1 = command byte, 0 = parameter/data byte
- wr_x  in  1  write strobe, active-low, pre-synchronized
- dat  in  8  host write data
- reg_we  out  1  one-cycle register write strobe
- reg_addr  out  5  register index
- reg_wdat  out  8  register data
- disp_on  out  1  display enable (DISP ON/OFF)
- csr_addr  out  ADDR_W  current cursor address
- vram_req  out  1  VRAM write request
- vram_addr  out  ADDR_W  VRAM write address
- vram_dat  out  8  VRAM write data
- vram_ack  in  1  VRAM write accepted
- busy  out  1  FIFO not empty
- ovf  out  1  sticky MWRITE overflow flag

## Operation
- Byte event: wr_x rising edge (registered 0, current 1) while registered cs_x = 0; a0/dat are taken from the registered copies.
- Command byte (a0 = 1) always aborts the current sequence; already-written params are kept; ovf is cleared.
- States: IDLE, PARAM (counted), CSRW, MWRITE.
- 0x40 SYSTEM SET: PARAM, 8 params → reg 0x00–0x07; P7/P8 also latched into internal AP (P7 low byte).
- 0x44 SCROLL: PARAM, 10 params → reg 0x08–0x11.
- 0x5A HDOT SCR → reg 0x12; 0x5B OVLAY → reg 0x13 (1 param each).
- 0x58/0x59 DISP OFF/ON: disp_on ← 0/1 at the command; 1 param → reg 0x14.
- 0x46 CSRW: CSRW state; P1 → csr_addr[7:0], P2 → csr_addr[15:8].
- 0x4C–0x4F CSRDIR: 0 params; step = +1 / −1 / −AP / +AP; return to IDLE.
- 0x42 MWRITE: each parameter pushes {csr_addr, dat}; csr_addr += step (mod 2^ADDR_W); unlimited count.
- Parameters after the count is exhausted, or in IDLE: ignored. Unknown commands → IDLE.
- FIFO full on an MWRITE byte: byte dropped, cursor not advanced, ovf ← 1.
- vram_req = FIFO non-empty; vram_addr/vram_dat = head entry, stable until ack; vram_ack with vram_req high pops one entry. vram_ack with vram_req low is ignored.

## Timing
- Reset values: reg_we 0, reg_addr 0, reg_wdat 0, disp_on 0, csr_addr 0, step +1, AP 0, FIFO empty, vram_req 0, busy 0, ovf 0, state IDLE.
- Cycle N: wr_x sampled 1 after 0. Cycle N+1: reg_we high for exactly 1 cycle; csr_addr updated; FIFO push visible, so vram_req rises at N+1 if the FIFO was empty.
- Simultaneous push and pop: both take effect; a full FIFO with a same-cycle pop still counts as full (byte dropped).
- Throughput: one VRAM write per cycle with vram_ack held high.
- Reset mid-operation: FIFO flushed, vram_req drops the next cycle, all state returns to reset values.

## Configuration
- HCS_CSRDIR_EN defined: CSRDIR commands and the AP latch are implemented as above.
- Not defined: 0x4C–0x4F are treated as unknown commands, step is fixed at +1, and no AP register exists.

## Structure
- Shared package holds command opcodes (CMD_SYSSET 8'h40, CMD_MWRITE 8'h42, CMD_SCROLL 8'h44, CMD_CSRW 8'h46, CMD_CSRDIR0 8'h4C, CMD_DISPOFF 8'h58, CMD_DISPON 8'h59, CMD_HDOT 8'h5A, CMD_OVLAY 8'h5B), register base indices, param counts, and the state encoding.
- One sub-module: hcs_fifo (synchronous FIFO, width ADDR_W+8, depth FIFO_DEPTH, push/pop/full/empty).

## Test plan
- 0x40 then 30 87 07 27 48 EF 40 00 → reg_we ×8 at 0x00–0x07 with those bytes, one cycle after each wr_x rise; AP = 0x0040.
- 0x46, 00, 10; then 0x42, 22, 33, 44; vram_ack tied 1 → VRAM writes 0x1000=22, 0x1001=33, 0x1002=44; csr_addr = 0x1003; busy returns to 0.
- AP = 0x0040; 0x4F; CSRW 0x1000; MWRITE AA BB → addresses 0x1000, 0x1040 (with the macro). Without the macro → 0x1000, 0x1001.
- FIFO_DEPTH=4, vram_ack = 0, MWRITE of 5 bytes → 4 entries held, ovf = 1, csr_addr advanced by 4; a new command clears ovf.
- 0x40 with 3 params, then 0x59, 01 → regs 0x00–0x02 written, disp_on = 1, reg 0x14 = 01, no further SYSTEM SET writes.
- rst asserted with 3 FIFO entries pending → next cycle vram_req = 0, busy = 0, csr_addr = 0; no further VRAM writes.

Source files
------------

// File: rtl/host_cmd_seq_pkg.sv
// Shared opcodes, register bases, parameter counts and FSM states for host_cmd_seq.
package host_cmd_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PARAM,
    ST_CSRW,
    ST_MWRITE
  } hcs_state_t;

  localparam logic [7:0] CMD_SYSSET  = 8'h40;
  localparam logic [7:0] CMD_MWRITE  = 8'h42;
  localparam logic [7:0] CMD_SCROLL  = 8'h44;
  localparam logic [7:0] CMD_CSRW    = 8'h46;
  localparam logic [7:0] CMD_CSRDIR0 = 8'h4C;
  localparam logic [7:0] CMD_CSRDIR1 = 8'h4D;
  localparam logic [7:0] CMD_CSRDIR2 = 8'h4E;
  localparam logic [7:0] CMD_CSRDIR3 = 8'h4F;
  localparam logic [7:0] CMD_DISPOFF = 8'h58;
  localparam logic [7:0] CMD_DISPON  = 8'h59;
  localparam logic [7:0] CMD_HDOT    = 8'h5A;
  localparam logic [7:0] CMD_OVLAY   = 8'h5B;

  localparam logic [4:0] REG_SYSSET = 5'h00;
  localparam logic [4:0] REG_SCROLL = 5'h08;
  localparam logic [4:0] REG_HDOT   = 5'h12;
  localparam logic [4:0] REG_OVLAY  = 5'h13;
  localparam logic [4:0] REG_DISP   = 5'h14;
  localparam logic [4:0] REG_AP_LO  = 5'h06;
  localparam logic [4:0] REG_AP_HI  = 5'h07;

  localparam logic [3:0] N_SYSSET = 4'd8;
  localparam logic [3:0] N_SCROLL = 4'd10;
  localparam logic [3:0] N_SINGLE = 4'd1;
  localparam logic [3:0] N_CSRW   = 4'd2;

endpackage

// File: rtl/host_cmd_seq_fifo.sv
// Synchronous FIFO buffering {address, data} MWRITE entries on their way to VRAM.
module hcs_fifo
  import host_cmd_seq_pkg::*;
#(
  parameter int unsigned W     = 24,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/host_cmd_seq.sv
// Host command sequencer: decodes 8080-bus command/param bytes into register writes and VRAM writes.
// Optional: define HCS_CSRDIR_EN for CSRDIR commands and the AP register.
module host_cmd_seq
  import host_cmd_seq_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_x,
  input  logic              a0,
  input  logic              wr_x,
  input  logic [7:0]        dat,
  output logic              reg_we,
  output logic [4:0]        reg_addr,
  output logic [7:0]        reg_wdat,
  output logic              disp_on,
  output logic [ADDR_W-1:0] csr_addr,
  output logic              vram_req,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_dat,
  input  logic              vram_ack,
  output logic              busy,
  output logic              ovf
);

  logic              cs_q, a0_q, wr_q, ev;
  logic [7:0]        dat_q;
  hcs_state_t        state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic [4:0]        widx, widx_n;
  logic              reg_we_n, disp_n, ovf_n, push, full, empty;
  logic [4:0]        reg_addr_n;
  logic [7:0]        reg_wdat_n;
  logic [ADDR_W-1:0] csr_n, step;
  logic [ADDR_W+7:0] head;

`ifdef HCS_CSRDIR_EN
  logic [ADDR_W-1:0] ap, ap_n, step_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      ap   <= '0;
      step <= ADDR_W'(1);
    end else begin
      ap   <= ap_n;
      step <= step_n;
    end
  end
`else
  assign step = ADDR_W'(1);
`endif

  // Event fires on the cycle wr_x returns high; a0/dat come from the copies taken while it was low.
  assign ev = !wr_q && wr_x && !cs_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_q     <= 1'b1;
      a0_q     <= 1'b0;
      wr_q     <= 1'b1;
      dat_q    <= '0;
      state    <= ST_IDLE;
      cnt      <= '0;
      widx     <= '0;
      reg_we   <= 1'b0;
      reg_addr <= '0;
      reg_wdat <= '0;
      disp_on  <= 1'b0;
      csr_addr <= '0;
      ovf      <= 1'b0;
    end else begin
      cs_q     <= cs_x;
      a0_q     <= a0;
      wr_q     <= wr_x;
      dat_q    <= dat;
      state    <= state_n;
      cnt      <= cnt_n;
      widx     <= widx_n;
      reg_we   <= reg_we_n;
      reg_addr <= reg_addr_n;
      reg_wdat <= reg_wdat_n;
      disp_on  <= disp_n;
      csr_addr <= csr_n;
      ovf      <= ovf_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    widx_n     = widx;
    reg_we_n   = 1'b0;
    reg_addr_n = reg_addr;
    reg_wdat_n = reg_wdat;
    disp_n     = disp_on;
    csr_n      = csr_addr;
    ovf_n      = ovf;
    push       = 1'b0;
`ifdef HCS_CSRDIR_EN
    ap_n   = ap;
    step_n = step;
`endif
    if (ev && a0_q) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
      ovf_n   = 1'b0;
      case (dat_q)
        CMD_SYSSET: begin state_n = ST_PARAM; cnt_n = N_SYSSET; widx_n = REG_SYSSET; end
        CMD_SCROLL: begin state_n = ST_PARAM; cnt_n = N_SCROLL; widx_n = REG_SCROLL; end
        CMD_HDOT:   begin state_n = ST_PARAM; cnt_n = N_SINGLE; widx_n = REG_HDOT; end
        CMD_OVLAY:  begin state_n = ST_PARAM; cnt_n = N_SINGLE; widx_n = REG_OVLAY; end
        CMD_DISPOFF, CMD_DISPON: begin
          disp_n  = dat_q[0];
          state_n = ST_PARAM;
          cnt_n   = N_SINGLE;
          widx_n  = REG_DISP;
        end
        CMD_CSRW:   begin state_n = ST_CSRW; cnt_n = N_CSRW; end
        CMD_MWRITE: state_n = ST_MWRITE;
`ifdef HCS_CSRDIR_EN
        CMD_CSRDIR0: step_n = ADDR_W'(1);
        CMD_CSRDIR1: step_n = '1;
        CMD_CSRDIR2: step_n = -ap;
        CMD_CSRDIR3: step_n = ap;
`endif
        default: ;
      endcase
    end else if (ev) begin
      case (state)
        ST_PARAM: begin
          reg_we_n   = 1'b1;
          reg_addr_n = widx;
          reg_wdat_n = dat_q;
          widx_n     = widx + 5'd1;
          cnt_n      = cnt - 4'd1;
          if (cnt == 4'd1) state_n = ST_IDLE;
`ifdef HCS_CSRDIR_EN
          if (widx == REG_AP_LO) ap_n[7:0]  = dat_q;
          if (widx == REG_AP_HI) ap_n[15:8] = dat_q;
`endif
        end
        ST_CSRW: begin
          cnt_n = cnt - 4'd1;
          if (cnt == N_CSRW) begin
            csr_n[7:0] = dat_q;
          end else begin
            csr_n[15:8] = dat_q;
            state_n     = ST_IDLE;
          end
        end
        ST_MWRITE: begin
          if (full) begin
            ovf_n = 1'b1;
          end else begin
            push  = 1'b1;
            csr_n = csr_addr + step;
          end
        end
        default: ;
      endcase
    end
  end

  hcs_fifo #(
    .W     (ADDR_W + 8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({csr_addr, dat_q}),
    .pop   (vram_ack),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign vram_req  = !empty;
  assign busy      = !empty;
  assign vram_addr = head[ADDR_W+7:8];
  assign vram_dat  = head[7:0];

endmodule

// File: tb/tb_host_cmd_seq.sv
// Self-checking bench for host_cmd_seq: vector table, directed corner sequences, randomized model run.
`timescale 1ns/1ps
module tb_host_cmd_seq;

  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned FIFO_DEPTH = 4;
`ifdef HCS_CSRDIR_EN
  localparam logic [15:0] DIR_STEP = 16'h0040;
`else
  localparam logic [15:0] DIR_STEP = 16'h0001;
`endif

  logic              clk = 1'b0, rst = 1'b1;
  logic              cs_x = 1'b1, a0 = 1'b0, wr_x = 1'b1, vram_ack = 1'b0;
  logic [7:0]        dat = '0;
  logic              reg_we, disp_on, vram_req, busy, ovf;
  logic [4:0]        reg_addr;
  logic [7:0]        reg_wdat, vram_dat;
  logic [ADDR_W-1:0] csr_addr, vram_addr;

  int checks = 0, failures = 0;
  logic [23:0] got_vram[$];

  typedef struct {
    logic       a0;
    logic [7:0] d;
    logic       we;
    logic [4:0] ra;
    logic [7:0] rd;
    logic       disp;
  } vec_t;
  vec_t tv[$];

  // reference model state
  int          m_pend[$];
  int          m_csrw_left;
  bit          m_mw, m_disp;
  logic [15:0] m_csr, m_step, m_ap;
  logic [23:0] m_vram[$];

  always #5 clk = ~clk;

  host_cmd_seq #(.FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .cs_x(cs_x), .a0(a0), .wr_x(wr_x), .dat(dat),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdat(reg_wdat), .disp_on(disp_on),
    .csr_addr(csr_addr), .vram_req(vram_req), .vram_addr(vram_addr), .vram_dat(vram_dat),
    .vram_ack(vram_ack), .busy(busy), .ovf(ovf)
  );

  always @(negedge clk)
    if (!rst && vram_req && vram_ack) got_vram.push_back({vram_addr, vram_dat});

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // One host write; returns 1 ns after the edge where its effect becomes visible.
  task automatic host_wr(input logic c, input logic [7:0] d);
    @(posedge clk); #1; cs_x = 1'b0; a0 = c; dat = d; wr_x = 1'b0;
    @(posedge clk); #1; wr_x = 1'b1;
    @(posedge clk); #1; cs_x = 1'b1;
  endtask

  task automatic drain(input int unsigned limit, output int unsigned n);
    n = 0;
    while (busy && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_idle", busy, 0);
  endtask

  task automatic add_vec(input logic a, input logic [7:0] d, input logic we,
                         input logic [4:0] ra, input logic [7:0] rd, input logic dp);
    vec_t v;
    v.a0 = a; v.d = d; v.we = we; v.ra = ra; v.rd = rd; v.disp = dp;
    tv.push_back(v);
  endtask

  task automatic check_vram(input string name, input logic [23:0] exp[$]);
    check($sformatf("%s_count", name), got_vram.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      check($sformatf("%s_entry%0d", name, i),
            (i < got_vram.size()) ? got_vram[i] : 24'hxxxxxx, exp[i]);
  endtask

  task automatic model_cmd(input logic [7:0] c);
    m_pend.delete();
    m_csrw_left = 0;
    m_mw = 1'b0;
    case (c)
      8'h40: for (int i = 0; i < 8; i++) m_pend.push_back(i);
      8'h44: for (int i = 8; i < 18; i++) m_pend.push_back(i);
      8'h5A: m_pend.push_back(18);
      8'h5B: m_pend.push_back(19);
      8'h58: begin m_disp = 1'b0; m_pend.push_back(20); end
      8'h59: begin m_disp = 1'b1; m_pend.push_back(20); end
      8'h46: m_csrw_left = 2;
      8'h42: m_mw = 1'b1;
`ifdef HCS_CSRDIR_EN
      8'h4C: m_step = 16'h0001;
      8'h4D: m_step = 16'hFFFF;
      8'h4E: m_step = 16'h0000 - m_ap;
      8'h4F: m_step = m_ap;
`endif
      default: ;
    endcase
  endtask

  task automatic model_param(input logic [7:0] d, output bit we, output int ra);
    we = 1'b0;
    ra = 0;
    if (m_pend.size() > 0) begin
      ra = m_pend.pop_front();
      we = 1'b1;
      if (ra == 6) m_ap[7:0]  = d;
      if (ra == 7) m_ap[15:8] = d;
    end else if (m_csrw_left == 2) begin
      m_csr[7:0] = d;
      m_csrw_left = 1;
    end else if (m_csrw_left == 1) begin
      m_csr[15:8] = d;
      m_csrw_left = 0;
    end else if (m_mw) begin
      m_vram.push_back({m_csr, d});
      m_csr = m_csr + m_step;
    end
  endtask

  initial begin
    logic [7:0]  sys [8] = '{8'h30, 8'h87, 8'h07, 8'h27, 8'h48, 8'hEF, 8'h40, 8'h00};
    logic [7:0]  opts [16] = '{8'h40, 8'h42, 8'h42, 8'h42, 8'h44, 8'h46, 8'h46, 8'h4C,
                               8'h4D, 8'h4E, 8'h4F, 8'h58, 8'h59, 8'h5A, 8'h5B, 8'h61};
    logic [23:0] exp_q[$];
    int unsigned n;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_reg_we", reg_we, 0);
    check("rst_reg_addr", reg_addr, 0);
    check("rst_reg_wdat", reg_wdat, 0);
    check("rst_disp_on", disp_on, 0);
    check("rst_csr_addr", csr_addr, 0);
    check("rst_vram_req", vram_req, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);

    // register-path vector table
    add_vec(1, 8'h40, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) add_vec(0, sys[i], 1, 5'(i), sys[i], 0);
    add_vec(0, 8'h55, 0, 0, 0, 0);
    add_vec(1, 8'h40, 0, 0, 0, 0);
    add_vec(0, 8'h11, 1, 5'h00, 8'h11, 0);
    add_vec(0, 8'h22, 1, 5'h01, 8'h22, 0);
    add_vec(0, 8'h33, 1, 5'h02, 8'h33, 0);
    add_vec(1, 8'h59, 0, 0, 0, 1);
    add_vec(0, 8'h01, 1, 5'h14, 8'h01, 1);
    add_vec(0, 8'h02, 0, 0, 0, 1);
    add_vec(1, 8'h58, 0, 0, 0, 0);
    add_vec(1, 8'h5A, 0, 0, 0, 0);
    add_vec(0, 8'h9C, 1, 5'h12, 8'h9C, 0);
    add_vec(0, 8'h9D, 0, 0, 0, 0);
    foreach (tv[i]) begin
      host_wr(tv[i].a0, tv[i].d);
      check($sformatf("tv%0d_reg_we", i), reg_we, tv[i].we);
      check($sformatf("tv%0d_disp_on", i), disp_on, tv[i].disp);
      if (tv[i].we) begin
        check($sformatf("tv%0d_reg_addr", i), reg_addr, tv[i].ra);
        check($sformatf("tv%0d_reg_wdat", i), reg_wdat, tv[i].rd);
        @(posedge clk); #1;
        check($sformatf("tv%0d_we_pulse", i), reg_we, 0);
      end
    end

    // CSRW then MWRITE with ack tied high
    vram_ack = 1'b1;
    got_vram.delete();
    host_wr(1, 8'h46); host_wr(0, 8'h00); host_wr(0, 8'h10);
    check("csrw_addr", csr_addr, 16'h1000);
    host_wr(1, 8'h42); host_wr(0, 8'h22); host_wr(0, 8'h33); host_wr(0, 8'h44);
    check("mw_csr_after", csr_addr, 16'h1003);
    drain(20, n);
    exp_q = '{24'h100022, 24'h100133, 24'h100244};
    check_vram("mw", exp_q);

    // cursor direction +AP (AP = 0x0040 from the table's SYSTEM SET)
    got_vram.delete();
    host_wr(1, 8'h4F);
    host_wr(1, 8'h46); host_wr(0, 8'h00); host_wr(0, 8'h10);
    host_wr(1, 8'h42); host_wr(0, 8'hAA); host_wr(0, 8'hBB);
    check("dir_csr_after", csr_addr, 16'h1000 + 2 * DIR_STEP);
    drain(20, n);
    exp_q = '{{16'h1000, 8'hAA}, {16'h1000 + DIR_STEP, 8'hBB}};
    check_vram("dir", exp_q);
    host_wr(1, 8'h4C);

    // overflow with VRAM stalled
    vram_ack = 1'b0;
    got_vram.delete();
    host_wr(1, 8'h46); host_wr(0, 8'h00); host_wr(0, 8'h20);
    host_wr(1, 8'h42);
    check("ovf_idle_req", vram_req, 0);
    host_wr(0, 8'h50);
    check("ovf_req_rise", vram_req, 1);
    check("ovf_head_addr", vram_addr, 16'h2000);
    check("ovf_head_dat", vram_dat, 8'h50);
    host_wr(0, 8'h51); host_wr(0, 8'h52); host_wr(0, 8'h53);
    check("ovf_full_no_flag", ovf, 0);
    check("ovf_csr_4", csr_addr, 16'h2004);
    host_wr(0, 8'h54);
    check("ovf_flag", ovf, 1);
    check("ovf_csr_held", csr_addr, 16'h2004);
    check("ovf_head_stable", vram_addr, 16'h2000);
    host_wr(1, 8'h42);
    check("ovf_cleared", ovf, 0);
    check("ovf_busy_kept", busy, 1);
    vram_ack = 1'b1;
    drain(20, n);
    check("ovf_drain_cycles", n, 4);
    exp_q = '{24'h200050, 24'h200151, 24'h200252, 24'h200353};
    check_vram("ovf", exp_q);

    // reset with entries pending
    vram_ack = 1'b0;
    got_vram.delete();
    host_wr(1, 8'h46); host_wr(0, 8'h00); host_wr(0, 8'h30);
    host_wr(1, 8'h42); host_wr(0, 8'hA1); host_wr(0, 8'hA2); host_wr(0, 8'hA3);
    check("rstmid_busy_before", busy, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("rstmid_vram_req", vram_req, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_csr", csr_addr, 0);
    vram_ack = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("rstmid_no_writes", got_vram.size(), 0);

    // randomized command stream against the reference model (starts from reset state)
    got_vram.delete();
    m_csr = '0; m_step = 16'h0001; m_ap = '0; m_disp = 1'b0; m_mw = 1'b0; m_csrw_left = 0;
    for (int k = 0; k < 70; k++) begin
      logic [7:0] c;
      int         np;
      c = opts[$urandom_range(0, 15)];
      model_cmd(c);
      host_wr(1, c);
      check($sformatf("rnd%0d_cmd_we", k), reg_we, 0);
      check($sformatf("rnd%0d_disp", k), disp_on, m_disp);
      np = $urandom_range(0, 11);
      for (int j = 0; j < np; j++) begin
        logic [7:0] d;
        bit         we;
        int         ra;
        d = 8'($urandom);
        model_param(d, we, ra);
        host_wr(0, d);
        check($sformatf("rnd%0d_%0d_we", k, j), reg_we, we);
        if (we) begin
          check($sformatf("rnd%0d_%0d_addr", k, j), reg_addr, ra);
          check($sformatf("rnd%0d_%0d_wdat", k, j), reg_wdat, d);
        end
        check($sformatf("rnd%0d_%0d_csr", k, j), csr_addr, m_csr);
      end
    end
    drain(20, n);
    check("rnd_ovf", ovf, 0);
    check_vram("rnd", m_vram);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
